hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline stall/flush controller for the 5-stage MIPS core: resolves the hazards that operand forwarding cannot cover. It detects load-use and branch-in-ID operand hazards, tracks the multi-cycle mult/div unit, and drives the PC/IF-ID write enables, ID/EX bubble insertion and IF-ID flush. It sits beside the forwarding unit, consuming the same stage register fields, and also keeps saturating stall/flush performance counters.

## Interface
- MUL_LAT, 4: busy cycles after a mult/multu issue
- DIV_LAT, 32: busy cycles after a div/divu issue
- CNT_W, 32: performance counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- IDrs, IDrt  in  5 each  source register fields of the instruction in ID
- IDusesRs, IDusesRt  in  1 each  instruction in ID actually reads rs / rt
- IDisBranch  in  1  ID holds beq/bne/jr (operands compared in ID)
- IDbranchTaken  in  1  branch/jump in ID resolves taken
- IDmdOp  in  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as none)
- IDreadsHiLo  in  1  ID holds mfhi/mflo
- EXoutrd, MEMoutrd  in  5 each  destination register in EX / MEM
- EXoutRegWrite, MemoutRegWrite  in  1 each  EX / MEM writes the register file
- EXMemRead, MEMMemRead  in  1 each  EX / MEM instruction is a load
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register write enable
- IDEXBubble  out  1  zero the ID/EX control fields
- IFIDFlush  out  1  zero the IF/ID instruction
- mdBusy  out  1  mult/div unit busy
- stallCycles, flushCount  out  CNT_W each  performance counters

## Operation
- Register match: a term matches only if the destination is nonzero, its RegWrite is set, and the corresponding IDuses bit is set.
- loadUse = EXMemRead & EXrd matches IDrs or IDrt.
- brHaz = IDisBranch & (EXrd matches under EXoutRegWrite, or MEMoutrd matches under MEMMemRead & MemoutRegWrite).
- mdHaz = mdBusy & (IDreadsHiLo | IDmdOp is 01 or 10).
- stall = loadUse | brHaz | mdHaz.
- When stall is set: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
- IFIDFlush = IDbranchTaken & !stall. A stalled branch never flushes until it is released.
- Mult/div counter mdCnt (6 bits): an issue occurs when IDmdOp is 01 or 10 and stall=0. An issue loads MUL_LAT or DIV_LAT. Otherwise the counter decrements if nonzero.
- mdBusy = (mdCnt != 0).
- stallCycles increments on each cycle with stall=1. flushCount increments on each cycle with IFIDFlush=1. Both saturate at all-ones and never wrap.
- Reset: mdCnt=0 and both counters=0. While rst is high the outputs are forced to PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, mdBusy=0. Reset mid-division aborts the busy window immediately.

## Timing
- stall and flush outputs are combinational from the current inputs and the registered mdCnt, with zero-cycle latency. mdBusy is a registered decode.
- Load-use hazard: exactly 1 stall cycle.
- Branch depending on an ALU op in EX: 1 stall cycle.
- Branch depending on a load in EX: 2 stall cycles (the EX term, then the MEM term).
- Mult issued unstalled in cycle t: mdBusy is high in t+1..t+MUL_LAT. A dependent mfhi in ID is stalled through t+MUL_LAT and proceeds in t+MUL_LAT+1.
- A mult/div in ID during a mult/div busy window stalls. It issues in the first cycle with mdBusy=0.
- If a load-use hazard and a md issue coincide, the issue is deferred because stall=1, so the counter is not loaded.

## Structure
- Shared package pipe_pkg holds:
  - MD_NONE/MD_MUL/MD_DIV encodings
  - MUL_LAT/DIV_LAT defaults
  - the 5-bit register index type
- One sub-module, md_busy_counter: load value, issue strobe and rst in; mdBusy out.
- Hazard decode and the perf counters stay in the top level.

## Test plan
- lw $2 in EX (EXMemRead=1, EXrd=2), add using rs=2 in ID -> exactly one cycle of PCWrite=0/IDEXBubble=1; stallCycles=1.
- beq rs=3 in ID, lw $3 in EX -> 2 stall cycles, then IDbranchTaken=1 gives IFIDFlush=1 for one cycle; flushCount=1.
- Destination $0 with RegWrite=1 matching IDrs=0 -> no stall.
- mult issued at cycle 10, mfhi in ID from cycle 11 -> stall cycles 11–14, released at 15; mdBusy high 11–14.
- div issued, rst asserted at busy cycle 5 -> mdCnt=0, mdBusy=0 next cycle, a waiting mflo proceeds.
- Drive stall=1 for 2^CNT_W+3 cycles with CNT_W overridden to 4 -> stallCycles holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register index type, mult/div opcode encodings
// and the default mult/div latencies used by the hazard logic.
package pipe_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_RSVD = 2'b11
    } md_op_e;

    localparam int MUL_LAT_DEFAULT = 4;
    localparam int DIV_LAT_DEFAULT = 32;
    localparam int MD_CNT_W        = 6;

    typedef struct packed {
        logic loadUse;
        logic brEx;
        logic brMem;
        logic md;
    } hazard_t;

    // A producer only matters if it really writes a nonzero register the consumer reads.
    function automatic logic reg_match(input reg_idx_t dst, input logic regWrite,
                                       input reg_idx_t src, input logic uses);
        return (dst != '0) && regWrite && uses && (dst == src);
    endfunction

    function automatic logic md_valid(input logic [1:0] op);
        return (op == MD_MUL) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Down-counter tracking the remaining busy cycles of the multi-cycle mult/div unit.
module md_busy_counter
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue,
    input  logic [MD_CNT_W-1:0] loadVal,
    output logic                mdBusy
);

    logic [MD_CNT_W-1:0] mdCnt;

    always_ff @(posedge clk) begin
        if (rst)
            mdCnt <= '0;
        else if (issue)
            mdCnt <= loadVal;
        else if (mdCnt != '0)
            mdCnt <= mdCnt - 1'b1;
    end

    // Reset aborts a busy window in the same cycle, not only after the edge.
    assign mdBusy = (mdCnt != '0) && !rst;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch-in-ID and
// mult/div hazards, plus saturating stall/flush performance counters.
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic             IDusesRs,
    input  logic             IDusesRt,
    input  logic             IDisBranch,
    input  logic             IDbranchTaken,
    input  logic [1:0]       IDmdOp,
    input  logic             IDreadsHiLo,
    input  logic [4:0]       EXoutrd,
    input  logic [4:0]       MEMoutrd,
    input  logic             EXoutRegWrite,
    input  logic             MemoutRegWrite,
    input  logic             EXMemRead,
    input  logic             MEMMemRead,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_LAT);

    hazard_t             haz;
    logic                exMatch;
    logic                memMatch;
    logic                stallRaw;
    logic                stall;
    logic                flush;
    logic                mdIssue;
    logic [MD_CNT_W-1:0] mdLoad;

    always_comb begin
        exMatch  = reg_match(EXoutrd, EXoutRegWrite, IDrs, IDusesRs)
                 | reg_match(EXoutrd, EXoutRegWrite, IDrt, IDusesRt);
        // Only a load still in MEM is too late for the ID-stage comparator.
        memMatch = reg_match(MEMoutrd, MemoutRegWrite & MEMMemRead, IDrs, IDusesRs)
                 | reg_match(MEMoutrd, MemoutRegWrite & MEMMemRead, IDrt, IDusesRt);

        haz.loadUse = EXMemRead & exMatch;
        haz.brEx    = IDisBranch & exMatch;
        haz.brMem   = IDisBranch & memMatch;
        haz.md      = mdBusy & (IDreadsHiLo | md_valid(IDmdOp));

        stallRaw = haz.loadUse | haz.brEx | haz.brMem | haz.md;
        stall    = stallRaw & !rst;
        flush    = IDbranchTaken & !stallRaw & !rst;
    end

    always_comb begin
        PCWrite    = !stall;
        IFIDWrite  = !stall;
        IDEXBubble = stall;
        IFIDFlush  = flush;
    end

    // A stalled mult/div must not start the unit; it issues once released.
    assign mdIssue = md_valid(IDmdOp) & !stallRaw & !rst;
    assign mdLoad  = (IDmdOp == MD_DIV) ? DIV_LOAD : MUL_LOAD;

    md_busy_counter u_md_busy_counter (
        .clk     (clk),
        .rst     (rst),
        .issue   (mdIssue),
        .loadVal (mdLoad),
        .mdBusy  (mdBusy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (stall && (stallCycles != '1))
                stallCycles <= stallCycles + 1'b1;
            if (flush && (flushCount != '1))
                flushCount <= flushCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl, with a second instance
// using 4-bit counters to exercise saturation.
module tb_hazard_stall_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IDrs, IDrt, EXoutrd, MEMoutrd;
    logic        IDusesRs, IDusesRt, IDisBranch, IDbranchTaken, IDreadsHiLo;
    logic [1:0]  IDmdOp;
    logic        EXoutRegWrite, MemoutRegWrite, EXMemRead, MEMMemRead;
    logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, mdBusy;
    logic [31:0] stallCycles, flushCount;
    logic        satPCWrite, satIFIDWrite, satIDEXBubble, satIFIDFlush, satMdBusy;
    logic [3:0]  satStallCycles, satFlushCount;

    int checks = 0;
    int errors = 0;
    int expStalls = 0;
    int expFlushes = 0;
    int busyCount;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst), .IDrs(IDrs), .IDrt(IDrt), .IDusesRs(IDusesRs), .IDusesRt(IDusesRt),
        .IDisBranch(IDisBranch), .IDbranchTaken(IDbranchTaken), .IDmdOp(IDmdOp),
        .IDreadsHiLo(IDreadsHiLo), .EXoutrd(EXoutrd), .MEMoutrd(MEMoutrd),
        .EXoutRegWrite(EXoutRegWrite), .MemoutRegWrite(MemoutRegWrite),
        .EXMemRead(EXMemRead), .MEMMemRead(MEMMemRead), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble), .IFIDFlush(IFIDFlush),
        .mdBusy(mdBusy), .stallCycles(stallCycles), .flushCount(flushCount)
    );

    hazard_stall_ctrl #(.CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .IDrs(IDrs), .IDrt(IDrt), .IDusesRs(IDusesRs), .IDusesRt(IDusesRt),
        .IDisBranch(IDisBranch), .IDbranchTaken(IDbranchTaken), .IDmdOp(IDmdOp),
        .IDreadsHiLo(IDreadsHiLo), .EXoutrd(EXoutrd), .MEMoutrd(MEMoutrd),
        .EXoutRegWrite(EXoutRegWrite), .MemoutRegWrite(MemoutRegWrite),
        .EXMemRead(EXMemRead), .MEMMemRead(MEMMemRead), .PCWrite(satPCWrite),
        .IFIDWrite(satIFIDWrite), .IDEXBubble(satIDEXBubble), .IFIDFlush(satIFIDFlush),
        .mdBusy(satMdBusy), .stallCycles(satStallCycles), .flushCount(satFlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic uRs, input logic [4:0] rt,
                                 input logic uRt, input logic br, input logic tk,
                                 input logic [1:0] md, input logic hl,
                                 input logic [4:0] exRd, input logic exW, input logic exL,
                                 input logic [4:0] memRd, input logic memW, input logic memL);
        IDrs = rs; IDusesRs = uRs; IDrt = rt; IDusesRt = uRt;
        IDisBranch = br; IDbranchTaken = tk; IDmdOp = md; IDreadsHiLo = hl;
        EXoutrd = exRd; EXoutRegWrite = exW; EXMemRead = exL;
        MEMoutrd = memRd; MemoutRegWrite = memW; MEMMemRead = memL;
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at posedge+1: samples at the falling edge, then advances one cycle.
    task automatic checkOutput(input string tag, input logic ePC, input logic eIFID,
                               input logic eBub, input logic eFlush, input logic eBusy);
        #4;
        chk({tag, ".PCWrite"}, 32'(PCWrite), 32'(ePC));
        chk({tag, ".IFIDWrite"}, 32'(IFIDWrite), 32'(eIFID));
        chk({tag, ".IDEXBubble"}, 32'(IDEXBubble), 32'(eBub));
        chk({tag, ".IFIDFlush"}, 32'(IFIDFlush), 32'(eFlush));
        chk({tag, ".mdBusy"}, 32'(mdBusy), 32'(eBusy));
        chk({tag, ".stallCycles"}, stallCycles, 32'(expStalls));
        chk({tag, ".flushCount"}, flushCount, 32'(expFlushes));
        if (rst) begin
            expStalls = 0;
            expFlushes = 0;
        end else begin
            expStalls += int'(eBub);
            expFlushes += int'(eFlush);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        rst = 1'b1;
        applyStimulus(2, 1, 0, 0, 1, 1, 2'b01, 1, 2, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("reset", 1, 1, 0, 0, 0);
        rst = 1'b0;

        applyStimulus(2, 1, 0, 0, 0, 0, 2'b00, 0, 2, 1, 1, 0, 0, 0);
        checkOutput("lu.stall", 0, 0, 1, 0, 0);
        applyStimulus(2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2, 1, 1);
        checkOutput("lu.release", 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 7, 1, 0, 0, 2'b00, 0, 7, 1, 1, 0, 0, 0);
        checkOutput("lu.rt", 0, 0, 1, 0, 0);
        applyStimulus(4, 0, 0, 0, 0, 0, 2'b00, 0, 4, 1, 1, 0, 0, 0);
        checkOutput("lu.notused", 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 1, 0, 2'b00, 0, 0, 1, 1, 0, 1, 1);
        checkOutput("zero.dest", 1, 1, 0, 0, 0);

        applyStimulus(6, 1, 0, 0, 1, 0, 2'b00, 0, 6, 1, 0, 0, 0, 0);
        checkOutput("br.alu.stall", 0, 0, 1, 0, 0);
        applyStimulus(6, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 6, 1, 0);
        checkOutput("br.alu.flush", 1, 1, 0, 1, 0);
        applyStimulus(6, 1, 0, 0, 1, 0, 2'b00, 0, 6, 0, 0, 0, 0, 0);
        checkOutput("br.nowrite", 1, 1, 0, 0, 0);
        applyStimulus(3, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 3, 0, 1);
        checkOutput("br.mem.nowrite", 1, 1, 0, 0, 0);

        applyStimulus(3, 1, 5, 1, 1, 1, 2'b00, 0, 3, 1, 1, 0, 0, 0);
        checkOutput("br.lw.ex", 0, 0, 1, 0, 0);
        applyStimulus(3, 1, 5, 1, 1, 1, 2'b00, 0, 0, 0, 0, 3, 1, 1);
        checkOutput("br.lw.mem", 0, 0, 1, 0, 0);
        applyStimulus(3, 1, 5, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("br.lw.flush", 1, 1, 0, 1, 0);
        applyIdle();
        checkOutput("br.lw.after", 1, 1, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mul.issue", 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) checkOutput("mfhi.stall", 0, 0, 1, 0, 1);
        checkOutput("mfhi.release", 1, 1, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mul2.issue", 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) checkOutput("div.wait", 0, 0, 1, 0, 1);
        checkOutput("div.issue", 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) checkOutput("mflo.stall", 0, 0, 1, 0, 1);
        rst = 1'b1;
        checkOutput("div.rst", 1, 1, 0, 0, 0);
        rst = 1'b0;
        checkOutput("mflo.release", 1, 1, 0, 0, 0);

        applyStimulus(2, 1, 0, 0, 0, 0, 2'b01, 0, 2, 1, 1, 0, 0, 0);
        checkOutput("coinc.stall", 0, 0, 1, 0, 0);
        applyStimulus(2, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 2, 1, 1);
        checkOutput("coinc.issue", 1, 1, 0, 0, 0);
        applyIdle();
        for (int i = 0; i < 4; i++) checkOutput("coinc.busy", 1, 1, 0, 0, 1);
        checkOutput("coinc.done", 1, 1, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("divlen.issue", 1, 1, 0, 0, 0);
        applyIdle();
        busyCount = 0;
        for (int i = 0; i < 40; i++) begin
            #4;
            if (mdBusy) busyCount++;
            @(posedge clk);
            #1;
        end
        chk("div.length", 32'(busyCount), 32'(DIV_LAT_DEFAULT));

        rst = 1'b1;
        checkOutput("sat.rst", 1, 1, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(2, 1, 0, 0, 0, 0, 2'b00, 0, 2, 1, 1, 0, 0, 0);
        for (int i = 0; i < 19; i++) checkOutput("sat.stall", 0, 0, 1, 0, 0);
        applyIdle();
        checkOutput("sat.end", 1, 1, 0, 0, 0);
        chk("sat.stallCycles", 32'(satStallCycles), 32'd15);
        chk("sat.flushCount", 32'(satFlushCount), 32'd0);
        chk("sat.PCWrite", 32'(satPCWrite), 32'd1);
        chk("sat.IFIDWrite", 32'(satIFIDWrite), 32'd1);
        chk("sat.IDEXBubble", 32'(satIDEXBubble), 32'd0);
        chk("sat.IFIDFlush", 32'(satIFIDFlush), 32'd0);
        chk("sat.mdBusy", 32'(satMdBusy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
